fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, sets instruction queue entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 32'h0, sets the fetch PC loaded on reset.
REQ-003 iClk  input  1  sole clock; all state updates on rising edge.
REQ-004 iReset  input  1  asynchronous, active-high reset.
REQ-005 oMemReq  output  1  fetch request valid toward instruction memory.
REQ-006 oMemAddr  output  32  fetch byte address (word-aligned).
REQ-007 iMemGnt  input  1  request accepted this cycle; ignored while oMemReq=0.
REQ-008 iMemRvalid  input  1  read data valid for the single outstanding request.
REQ-009 iMemRdata  input  32  instruction word returned by memory.
REQ-010 oInstValid  output  1  queue head holds a valid instruction for decode.
REQ-011 oInst  output  32  instruction at queue head.
REQ-012 oInstPc  output  32  byte address of oInst.
REQ-013 iInstReady  input  1  decode consumes head when oInstValid=1.
REQ-014 iRedirect  input  1  branch/jump redirect; flushes fetch path.
REQ-015 iRedirectPc  input  32  new fetch address; bits [1:0] forced to 0.

Function
REQ-016 Fetch PC register fpc drives oMemAddr; fpc advances by 4 on each accepted request, wrapping modulo 2^32.
REQ-017 FSM states: IDLE (none outstanding), WAIT (one outstanding, data kept), DROP (one outstanding, data discarded); at most one outstanding request.
REQ-018 oMemReq=1 only in IDLE, with iRedirect=0 and queue count < DEPTH.
REQ-019 IDLE and iMemGnt while oMemReq=1: latch reqpc=fpc, fpc+=4, go WAIT.
REQ-020 oMemAddr held stable while oMemReq=1 and iMemGnt=0.
REQ-021 WAIT and iMemRvalid, no redirect: push {iMemRdata, reqpc} into queue, go IDLE; new request earliest next cycle.
REQ-022 Queue is FIFO; oInstValid = (count != 0); head popped when oInstValid and iInstReady; push and pop in the same cycle leave count unchanged.
REQ-023 Queue overflow impossible: REQ-018 guarantees a free slot for every outstanding response.
REQ-024 iRedirect: fpc <= iRedirectPc & ~3, queue count <= 0 (redirect beats same-cycle pop and push); IDLE stays IDLE; WAIT with iMemRvalid=0 goes DROP; WAIT with iMemRvalid=1 discards data, goes IDLE.
REQ-025 DROP and iMemRvalid: discard data, go IDLE; a further redirect in DROP updates fpc and stays DROP.
REQ-026 iMemRvalid in IDLE is ignored.
REQ-027 Baseline latency: iMemRvalid in cycle N -> oInstValid=1 with that word in cycle N+1.

Reset
REQ-028 iReset asserted: state IDLE, fpc=RESET_PC, queue count=0, reqpc=0, queue storage contents need not be cleared.
REQ-029 During reset oMemReq=0, oInstValid=0, oInst=0, oInstPc=0; first request, at RESET_PC, issues in first cycle after deassertion.
REQ-030 Reset mid-operation abandons any outstanding request; its late response is ignored per REQ-026.

Configuration
REQ-031 Macro FETCH_BYPASS_EN defined: when queue empty and state WAIT, iMemRvalid drives oInstValid=1, oInst=iMemRdata, oInstPc=reqpc combinationally same cycle; if iInstReady=1 the word is not written to the queue.
REQ-032 FETCH_BYPASS_EN undefined: no bypass path; latency per REQ-027.

Verification
REQ-033 Reset release, iMemGnt=1, 1-cycle memory, iInstReady=1 -> oMemAddr 0,4,8,...; oInstPc sequence 0,4,8 with matching words, no gaps beyond 1 idle cycle per fetch.
REQ-034 iInstReady=0, DEPTH=4 -> after 4 pushes oMemReq=0, count=4; iInstReady=1 for one cycle -> oMemReq returns next cycle, addr 0x10.
REQ-035 Redirect to 0x103 in WAIT, response 2 cycles later -> response dropped, next oMemAddr=0x100, first oInstPc=0x100, queue empty meanwhile.
REQ-036 iRedirect and iMemRvalid same cycle in WAIT, queue holding 2 entries -> oInstValid=0 next cycle, next request at redirect PC.
REQ-037 Reset pulse while WAIT, then iMemRvalid=1 -> response ignored, oMemAddr=RESET_PC, oInstValid stays 0.
REQ-038 FETCH_BYPASS_EN defined, queue empty, iInstReady=1 -> oInstValid=1 in same cycle as iMemRvalid, count stays 0.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. Issues one word-aligned fetch at a time
//   toward instruction memory, collects the returned words into a small
//   FIFO and presents them to decode. A redirect flushes the FIFO, reloads
//   the fetch PC and discards any response still in flight.
//
// Parameters
//   DEPTH     instruction queue entries (power of two, 2..16)
//   RESET_PC  fetch PC loaded on reset
//
// Optional feature macro
//   FETCH_BYPASS_EN  when defined, a response arriving while the queue is
//                    empty is forwarded to decode in the same cycle.
//
// Ports
//   iClk, iReset        clock, asynchronous active-high reset
//   oMemReq, oMemAddr   fetch request / byte address toward memory
//   iMemGnt             request accepted this cycle
//   iMemRvalid/Rdata    response for the single outstanding request
//   oInstValid, oInst,  queue head toward decode
//   oInstPc
//   iInstReady          decode consumes the head
//   iRedirect,          flush and restart fetch at iRedirectPc (low bits
//   iRedirectPc         forced to zero)
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        iClk,
  input  logic        iReset,
  output logic        oMemReq,
  output logic [31:0] oMemAddr,
  input  logic        iMemGnt,
  input  logic        iMemRvalid,
  input  logic [31:0] iMemRdata,
  output logic        oInstValid,
  output logic [31:0] oInst,
  output logic [31:0] oInstPc,
  input  logic        iInstReady,
  input  logic        iRedirect,
  input  logic [31:0] iRedirectPc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // IDLE: nothing outstanding; WAIT: response will be kept;
  // DROP: response will be discarded (a redirect overtook it).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fpc_q, fpc_d;
  logic [31:0]     reqpc_q, reqpc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     inst_mem_q [DEPTH];
  logic [31:0]     pc_mem_q   [DEPTH];

  logic            mem_req;
  logic            grant;
  logic            rsp_keep;
  logic            bypass;
  logic            push;
  logic            pop;
  logic            q_nonempty;

  // ---- FSM state register ----
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (grant) state_d = S_WAIT;
      // A response always closes the transaction, whether kept or not.
      S_WAIT: begin
        if (iMemRvalid)     state_d = S_IDLE;
        else if (iRedirect) state_d = S_DROP;
      end
      S_DROP: if (iMemRvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  // The request is gated by reset so nothing is issued while the block is
  // held; the count check reserves a slot for the response.
  always_comb begin
    mem_req  = (state_q == S_IDLE) && !iRedirect &&
               (count_q < CW'(DEPTH)) && !iReset;
    rsp_keep = (state_q == S_WAIT) && iMemRvalid && !iRedirect;
  end

  assign grant      = mem_req && iMemGnt;
  assign q_nonempty = (count_q != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_keep && !q_nonempty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that decode takes immediately never enters the queue.
  assign push = rsp_keep && !(bypass && iInstReady);
  assign pop  = q_nonempty && iInstReady;

  // ---- Fetch PC, request PC and queue control ----
  always_comb begin
    fpc_d    = fpc_q;
    reqpc_d  = reqpc_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (grant) begin
      reqpc_d = fpc_q;
      fpc_d   = fpc_q + 32'd4;
    end
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
    // Redirect wins over any same-cycle push or pop.
    if (iRedirect) begin
      fpc_d    = {iRedirectPc[31:2], 2'b00};
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      fpc_q    <= RESET_PC;
      reqpc_q  <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      reqpc_q  <= reqpc_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // ---- Queue storage (contents are don't-care until written) ----
  always_ff @(posedge iClk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= iMemRdata;
      pc_mem_q[wr_ptr_q]   <= reqpc_q;
    end
  end

  // ---- Outputs ----
  assign oMemReq    = mem_req;
  assign oMemAddr   = fpc_q;
  assign oInstValid = q_nonempty || bypass;
  assign oInst      = q_nonempty ? inst_mem_q[rd_ptr_q] :
                      (bypass ? iMemRdata : 32'h0);
  assign oInstPc    = q_nonempty ? pc_mem_q[rd_ptr_q] :
                      (bypass ? reqpc_q : 32'h0);

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit (default build, no bypass). Directed
//   scenarios cover reset, streaming, queue full, redirects and reset during
//   an outstanding fetch; a randomized run compares every cycle against a
//   queue-based model of the instruction stream decode should observe.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gnt = 1'b0;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rv;
  logic [31:0] rdata;
  logic        mreq;
  logic [31:0] maddr;
  logic        ivalid;
  logic [31:0] inst;
  logic [31:0] ipc;

  bit          mem_en = 1'b0;
  bit          mem_spur = 1'b0;
  int unsigned mem_lat_max = 0;

  int n_pass = 0;
  int n_total = 0;

  assign rv    = mem_en ? mem_rvalid : man_rvalid;
  assign rdata = mem_en ? mem_rdata  : man_rdata;

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .iClk       (clk),
    .iReset     (rst),
    .oMemReq    (mreq),
    .oMemAddr   (maddr),
    .iMemGnt    (gnt),
    .iMemRvalid (rv),
    .iMemRdata  (rdata),
    .oInstValid (ivalid),
    .oInst      (inst),
    .oInstPc    (ipc),
    .iInstReady (ready),
    .iRedirect  (redir),
    .iRedirectPc(redir_pc)
  );

  always #5 clk = ~clk;

  // Instruction word stored at a byte address in the bench's memory.
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0DE_0000;
  endfunction

  // Memory responder: one outstanding request, answer after 1+cd cycles.
  bit          pend = 1'b0;
  int unsigned cd = 0;
  logic [31:0] paddr = 32'h0;
  always @(negedge clk) begin
    if (rst || !mem_en) begin
      pend       = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
    end else if (pend && cd == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = word(paddr);
      pend       = 1'b0;
    end else begin
      mem_rvalid = mem_spur && !pend && ($urandom_range(7) == 0);
      mem_rdata  = $urandom;
      if (pend) cd = cd - 1;
    end
    #2;
    if (mem_en && !rst && mreq && gnt) begin
      pend  = 1'b1;
      paddr = maddr;
      cd    = $urandom_range(mem_lat_max, 0);
    end
  end

  task automatic do_reset();
    rst = 1'b1; gnt = 1'b0; ready = 1'b0; redir = 1'b0; redir_pc = 32'h0;
    man_rvalid = 1'b0; man_rdata = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mem_en = 1'b0;
    rst = 1'b1; gnt = 1'b1; ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    #1;
    n_total++; if (mreq !== 1'b0) $display("FAIL reset_memreq: got %b want 0", mreq); else n_pass++;
    n_total++; if (ivalid !== 1'b0) $display("FAIL reset_instvalid: got %b want 0", ivalid); else n_pass++;
    n_total++; if (inst !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst); else n_pass++;
    n_total++; if (ipc !== 32'h0) $display("FAIL reset_instpc: got %h want 0", ipc); else n_pass++;
    @(negedge clk);
    rst = 1'b0; man_rvalid = 1'b0;
    #1;
    n_total++; if (mreq !== 1'b1) $display("FAIL reset_first_req: got %b want 1", mreq); else n_pass++;
    n_total++; if (maddr !== RESET_PC) $display("FAIL reset_first_addr: got %h want %h", maddr, RESET_PC); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_stream();
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] exp_pc = RESET_PC;
    mem_en = 1'b1; mem_spur = 1'b0; mem_lat_max = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      gnt = 1'b1; ready = 1'b1;
      #1;
      if (mreq) begin
        n_total++; if (maddr !== exp_addr) $display("FAIL stream_addr: got %h want %h", maddr, exp_addr); else n_pass++;
        exp_addr = exp_addr + 32'd4;
      end
      if (ivalid) begin
        n_total++; if (ipc !== exp_pc) $display("FAIL stream_pc: got %h want %h", ipc, exp_pc); else n_pass++;
        n_total++; if (inst !== word(exp_pc)) $display("FAIL stream_inst: got %h want %h", inst, word(exp_pc)); else n_pass++;
        exp_pc = exp_pc + 32'd4;
      end
      @(negedge clk);
    end
    // One fetch per two cycles: 6 requests, 5 delivered in 12 cycles.
    n_total++; if (exp_addr !== 32'd24) $display("FAIL stream_req_count: got %h want %h", exp_addr, 32'd24); else n_pass++;
    n_total++; if (exp_pc !== 32'd20) $display("FAIL stream_inst_count: got %h want %h", exp_pc, 32'd20); else n_pass++;
  endtask

  task automatic test_full();
    int drained = 0;
    logic [31:0] exp_pc = 32'h4;
    mem_en = 1'b1; mem_spur = 1'b0; mem_lat_max = 0;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    repeat (10) @(negedge clk);
    ready = 1'b1;
    #1;
    n_total++; if (mreq !== 1'b0) $display("FAIL full_memreq: got %b want 0", mreq); else n_pass++;
    n_total++; if (ivalid !== 1'b1) $display("FAIL full_valid: got %b want 1", ivalid); else n_pass++;
    n_total++; if (ipc !== 32'h0) $display("FAIL full_head_pc: got %h want 0", ipc); else n_pass++;
    n_total++; if (inst !== word(32'h0)) $display("FAIL full_head_inst: got %h want %h", inst, word(32'h0)); else n_pass++;
    @(negedge clk);
    ready = 1'b0; gnt = 1'b0;
    #1;
    n_total++; if (mreq !== 1'b1) $display("FAIL full_req_back: got %b want 1", mreq); else n_pass++;
    n_total++; if (maddr !== 32'h10) $display("FAIL full_req_addr: got %h want 10", maddr); else n_pass++;
    n_total++; if (ipc !== 32'h4) $display("FAIL full_next_pc: got %h want 4", ipc); else n_pass++;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      ready = 1'b1;
      #1;
      if (ivalid) begin
        n_total++; if (ipc !== exp_pc) $display("FAIL full_drain_pc: got %h want %h", ipc, exp_pc); else n_pass++;
        exp_pc = exp_pc + 32'd4;
        drained++;
      end
      @(negedge clk);
    end
    n_total++; if (drained !== 3) $display("FAIL full_drain_count: got %0d want 3", drained); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    mem_en = 1'b0;
    do_reset();
    gnt = 1'b1;
    #1;
    n_total++; if (mreq !== 1'b1 || maddr !== 32'h0) $display("FAIL rw_first_req: got %b/%h want 1/0", mreq, maddr); else n_pass++;
    @(negedge clk);
    gnt = 1'b0; redir = 1'b1; redir_pc = 32'h103;
    #1;
    n_total++; if (mreq !== 1'b0) $display("FAIL rw_req_on_redirect: got %b want 0", mreq); else n_pass++;
    @(negedge clk);
    redir = 1'b0;
    #1;
    n_total++; if (mreq !== 1'b0) $display("FAIL rw_req_in_drop: got %b want 0", mreq); else n_pass++;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rw_valid_in_drop: got %b want 0", ivalid); else n_pass++;
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    #1;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rw_valid_on_stale: got %b want 0", ivalid); else n_pass++;
    @(negedge clk);
    man_rvalid = 1'b0; gnt = 1'b1;
    #1;
    n_total++; if (mreq !== 1'b1 || maddr !== 32'h100) $display("FAIL rw_new_req: got %b/%h want 1/100", mreq, maddr); else n_pass++;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rw_stale_dropped: got %b want 0", ivalid); else n_pass++;
    @(negedge clk);
    gnt = 1'b0; man_rvalid = 1'b1; man_rdata = word(32'h100);
    #1;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rw_latency: got %b want 0", ivalid); else n_pass++;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    n_total++; if (ivalid !== 1'b1 || ipc !== 32'h100) $display("FAIL rw_first_inst: got %b/%h want 1/100", ivalid, ipc); else n_pass++;
    n_total++; if (inst !== word(32'h100)) $display("FAIL rw_first_word: got %h want %h", inst, word(32'h100)); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_redirect_rvalid();
    mem_en = 1'b0;
    do_reset();
    gnt = 1'b1; ready = 1'b0;
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = word(32'h0);
    @(negedge clk);
    man_rvalid = 1'b0;
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = word(32'h4);
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    n_total++; if (ivalid !== 1'b1 || ipc !== 32'h0) $display("FAIL rr_queue_head: got %b/%h want 1/0", ivalid, ipc); else n_pass++;
    @(negedge clk);
    gnt = 1'b0; redir = 1'b1; redir_pc = 32'h200; man_rvalid = 1'b1; man_rdata = word(32'h8);
    #1;
    n_total++; if (ivalid !== 1'b1) $display("FAIL rr_valid_before_flush: got %b want 1", ivalid); else n_pass++;
    @(negedge clk);
    redir = 1'b0; man_rvalid = 1'b0;
    #1;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rr_flushed: got %b want 0", ivalid); else n_pass++;
    n_total++; if (mreq !== 1'b1 || maddr !== 32'h200) $display("FAIL rr_next_req: got %b/%h want 1/200", mreq, maddr); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    mem_en = 1'b0;
    do_reset();
    gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    #1;
    n_total++; if (mreq !== 1'b0) $display("FAIL rst_wait_noreq: got %b want 0", mreq); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (mreq !== 1'b0 || ivalid !== 1'b0) $display("FAIL rst_wait_held: got %b/%b want 0/0", mreq, ivalid); else n_pass++;
    n_total++; if (inst !== 32'h0 || ipc !== 32'h0) $display("FAIL rst_wait_data: got %h/%h want 0/0", inst, ipc); else n_pass++;
    @(negedge clk);
    rst = 1'b0; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0;
    #1;
    n_total++; if (mreq !== 1'b1 || maddr !== RESET_PC) $display("FAIL rst_wait_req: got %b/%h want 1/%h", mreq, maddr, RESET_PC); else n_pass++;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rst_wait_valid: got %b want 0", ivalid); else n_pass++;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    n_total++; if (ivalid !== 1'b0) $display("FAIL rst_wait_late_rsp: got %b want 0", ivalid); else n_pass++;
    n_total++; if (maddr !== RESET_PC) $display("FAIL rst_wait_addr_hold: got %h want %h", maddr, RESET_PC); else n_pass++;
    @(negedge clk);
  endtask

  // Model: the instructions decode should see, in order, plus the next fetch
  // address and whether the single outstanding fetch is still wanted.
  task automatic test_random();
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] npc = RESET_PC;
    logic [31:0] opc = 32'h0;
    bit outst = 1'b0;
    bit keep = 1'b0;
    bit exp_req, exp_valid;
    mem_en = 1'b1; mem_spur = 1'b1; mem_lat_max = 2;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      redir    = ($urandom_range(15) == 0);
      redir_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      ready    = redir ? 1'b0 : 1'($urandom_range(1));
      gnt      = ($urandom_range(3) != 0);
      #1;
      exp_req   = !outst && !redir && (exp_pc_q.size() < DEPTH);
      exp_valid = (exp_pc_q.size() != 0);
      n_total++; if (mreq !== exp_req) $display("FAIL rnd_memreq c%0d: got %b want %b", c, mreq, exp_req); else n_pass++;
      if (exp_req) begin
        n_total++; if (maddr !== npc) $display("FAIL rnd_addr c%0d: got %h want %h", c, maddr, npc); else n_pass++;
      end
      n_total++; if (ivalid !== exp_valid) $display("FAIL rnd_valid c%0d: got %b want %b", c, ivalid, exp_valid); else n_pass++;
      if (exp_valid) begin
        n_total++; if (ipc !== exp_pc_q[0]) $display("FAIL rnd_pc c%0d: got %h want %h", c, ipc, exp_pc_q[0]); else n_pass++;
        n_total++; if (inst !== exp_inst_q[0]) $display("FAIL rnd_inst c%0d: got %h want %h", c, inst, exp_inst_q[0]); else n_pass++;
      end
      if (exp_valid && ready) begin
        void'(exp_pc_q.pop_front());
        void'(exp_inst_q.pop_front());
      end
      if (rv && outst) begin
        if (keep && !redir) begin
          exp_pc_q.push_back(opc);
          exp_inst_q.push_back(word(opc));
        end
        outst = 1'b0;
      end
      if (redir) begin
        exp_pc_q.delete();
        exp_inst_q.delete();
        npc  = {redir_pc[31:2], 2'b00};
        keep = 1'b0;
      end
      if (exp_req && gnt) begin
        outst = 1'b1;
        keep  = 1'b1;
        opc   = npc;
        npc   = npc + 32'd4;
      end
      @(negedge clk);
    end
    redir = 1'b0; gnt = 1'b0; ready = 1'b0;
    mem_en = 1'b0; mem_spur = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_rvalid();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
